param_updown_counter: RTL and testbench



---
 rtl/param_updown_counter_if.sv | 26 ++
 rtl/param_updown_counter.sv | 86 ++++++++
 tb/tb_param_updown_counter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter.
// The master drives the counter controls and the slave side returns count and status.
interface param_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up_dn, clr, load, load_val, clr_ovf,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, up_dn, clr, load, load_val, clr_ovf,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/param_updown_counter.sv
// Up/down modulo-MOD counter with clear, clamped load, enable,
// terminal-count, single-cycle wrap pulse and sticky overflow.
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    param_updown_counter_if.slave       bus
);
    // One extra bit so MOD itself is representable when MOD == 2**WIDTH.
    localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0]   LAST_X = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0]   ONE_X  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] LAST   = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             ovf_q;

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             ovf_set;
    logic             ovf_nxt;

    logic [WIDTH:0]   count_x;
    logic             at_top;
    logic             at_bot;

    assign count_x = {1'b0, count_q};
    assign at_top  = (count_x == LAST_X);
    assign at_bot  = (count_x == '0);

    always_comb begin
        count_nxt = count_q;
        wrap_nxt  = 1'b0;
        ovf_set   = 1'b0;
        if (bus.clr) begin
            count_nxt = '0;
        end else if (bus.load) begin
            count_nxt = ({1'b0, bus.load_val} >= MOD_X) ? LAST : bus.load_val;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (count_x < LAST_X) begin
                    count_nxt = WIDTH'(count_x + ONE_X);
                end else begin
                    ovf_set = 1'b1;
                    if (SATURATE == 0) begin
                        count_nxt = '0;
                        wrap_nxt  = 1'b1;
                    end
                end
            end else begin
                if (!at_bot) begin
                    count_nxt = WIDTH'(count_x - ONE_X);
                end else begin
                    ovf_set = 1'b1;
                    if (SATURATE == 0) begin
                        count_nxt = LAST;
                        wrap_nxt  = 1'b1;
                    end
                end
            end
        end
        // A set event on the same edge as clr_ovf leaves the flag set.
        ovf_nxt = ovf_set ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            wrap_q  <= wrap_nxt;
            ovf_q   <= ovf_nxt;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;
    assign bus.tc    = bus.en & ((bus.up_dn & at_top) | (~bus.up_dn & at_bot));
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed checks for param_updown_counter: wrapping MOD=10, saturating MOD=10
// and full-range MOD=16 instances sharing clock and reset.
module tb_param_updown_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    param_updown_counter_if #(.WIDTH(4)) iw ();
    param_updown_counter_if #(.WIDTH(4)) is ();
    param_updown_counter_if #(.WIDTH(4)) i16 ();

    param_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) dut_w (.clk(clk), .rst(rst), .bus(iw));
    param_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) dut_s (.clk(clk), .rst(rst), .bus(is));
    param_updown_counter #(.WIDTH(4), .MOD(16), .SATURATE(0)) dut_16 (.clk(clk), .rst(rst), .bus(i16));

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        iw.en = 0; iw.up_dn = 1; iw.clr = 0; iw.load = 0; iw.load_val = 0; iw.clr_ovf = 0;
        is.en = 0; is.up_dn = 1; is.clr = 0; is.load = 0; is.load_val = 0; is.clr_ovf = 0;
        i16.en = 0; i16.up_dn = 1; i16.clr = 0; i16.load = 0; i16.load_val = 0; i16.clr_ovf = 0;
        #2;
        chk("reset_count", iw.count, 0);
        chk("reset_wrap", iw.wrap, 0);
        chk("reset_ovf", iw.ovf, 0);

        // T1: load 7, then assert reset between edges
        step();
        rst = 1;
        iw.load = 1; iw.load_val = 7;
        step();
        iw.load = 0;
        chk("t1_loaded", iw.count, 7);
        iw.load = 1; iw.load_val = 3;
        #1 rst = 0;
        #1;
        chk("t1_async_count", iw.count, 0);
        chk("t1_async_wrap", iw.wrap, 0);
        chk("t1_async_ovf", iw.ovf, 0);
        step();
        chk("t1_load_discarded", iw.count, 0);
        iw.load = 0;
        #1 rst = 1;

        // T2: count up 12 steps from 0
        iw.en = 1; iw.up_dn = 1;
        for (int i = 1; i <= 12; i++) begin
            #1;
            chk($sformatf("t2_tc_%0d", i), iw.tc, ((i - 1) % 10 == 9) ? 1 : 0);
            step();
            chk($sformatf("t2_count_%0d", i), iw.count, i % 10);
            chk($sformatf("t2_wrap_%0d", i), iw.wrap, (i == 10) ? 1 : 0);
            chk($sformatf("t2_ovf_%0d", i), iw.ovf, (i >= 10) ? 1 : 0);
        end

        // hold when idle
        iw.en = 0;
        #1;
        chk("hold_tc", iw.tc, 0);
        step();
        chk("hold_count", iw.count, 2);

        // T3: load 0, then step down twice
        iw.load = 1; iw.load_val = 0;
        step();
        iw.load = 0;
        chk("t3_load0", iw.count, 0);
        iw.en = 1; iw.up_dn = 0;
        #1;
        chk("t3_tc", iw.tc, 1);
        step();
        chk("t3_count_9", iw.count, 9);
        chk("t3_wrap_9", iw.wrap, 1);
        step();
        chk("t3_count_8", iw.count, 8);
        chk("t3_wrap_8", iw.wrap, 0);
        // direction flip with no dead cycle
        iw.up_dn = 1;
        step();
        chk("t3_flip_up", iw.count, 9);
        iw.en = 0;

        // T4: saturating instance
        is.load = 1; is.load_val = 8;
        step();
        is.load = 0;
        chk("t4_load8", is.count, 8);
        is.en = 1; is.up_dn = 1;
        step();
        chk("t4_c1", is.count, 9);
        chk("t4_ovf1", is.ovf, 0);
        chk("t4_tc", is.tc, 1);
        step();
        chk("t4_c2", is.count, 9);
        chk("t4_wrap2", is.wrap, 0);
        chk("t4_ovf2", is.ovf, 1);
        step();
        chk("t4_c3", is.count, 9);
        chk("t4_wrap3", is.wrap, 0);
        is.en = 0; is.load = 1; is.load_val = 0; is.clr_ovf = 1;
        step();
        is.load = 0; is.clr_ovf = 0;
        chk("t4_ovf_cleared", is.ovf, 0);
        is.en = 1; is.up_dn = 0;
        step();
        chk("t4_down_hold", is.count, 0);
        chk("t4_down_wrap", is.wrap, 0);
        chk("t4_down_ovf", is.ovf, 1);
        is.en = 0;

        // T5: priority and load clamp
        iw.clr = 1; iw.load = 1; iw.load_val = 5; iw.en = 1; iw.up_dn = 1;
        step();
        chk("t5_clr_wins", iw.count, 0);
        iw.clr = 0; iw.en = 0; iw.load_val = 13;
        step();
        chk("t5_clamp13", iw.count, 9);
        iw.load_val = 4; iw.en = 1;
        step();
        chk("t5_load_over_en", iw.count, 4);
        chk("t5_load_wrap", iw.wrap, 0);
        iw.load_val = 10; iw.en = 0;
        step();
        chk("t5_clamp10", iw.count, 9);
        iw.load = 0;

        // T6: ovf set beats clr_ovf on the same edge
        iw.clr_ovf = 1;
        step();
        chk("t6_ovf_pre", iw.ovf, 0);
        iw.en = 1; iw.up_dn = 1;
        step();
        chk("t6_count", iw.count, 0);
        chk("t6_wrap", iw.wrap, 1);
        chk("t6_ovf_race", iw.ovf, 1);
        iw.en = 0;
        step();
        chk("t6_ovf_clear", iw.ovf, 0);
        chk("t6_wrap_drop", iw.wrap, 0);
        iw.clr_ovf = 0;

        // full-range modulus: explicit wrap compare both ways
        i16.load = 1; i16.load_val = 15;
        step();
        i16.load = 0; i16.en = 1; i16.up_dn = 1;
        #1;
        chk("m16_tc_up", i16.tc, 1);
        step();
        chk("m16_up_count", i16.count, 0);
        chk("m16_up_wrap", i16.wrap, 1);
        i16.up_dn = 0;
        step();
        chk("m16_down_count", i16.count, 15);
        chk("m16_down_wrap", i16.wrap, 1);
        chk("m16_ovf", i16.ovf, 1);
        i16.en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
